// File: rtl/otter_intr_ctrl.sv
// Memory-mapped interrupt controller for the OTTER iobus: per-source synchronizers,
// edge/level pending capture, lowest-index priority and single-level service tracking.
module otter_intr_ctrl #(
   parameter int unsigned N_CHAN      = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h1100_0200,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CHAN-1:0] irq_src,
   input  logic [31:0]       iobus_addr,
   input  logic [31:0]       iobus_out,
   input  logic              iobus_wr,
   output logic [31:0]       iobus_rd_data,
   input  logic              intrpt_ack,
   output logic              intrpt,
   output logic [4:0]        irq_id
);

   localparam int unsigned ID_W   = 5;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned SETTLE = SYNC_STAGES + 1;

   localparam logic [2:0] OFF_PEND = 3'd0;
   localparam logic [2:0] OFF_EN   = 3'd1;
   localparam logic [2:0] OFF_EDGE = 3'd2;
   localparam logic [2:0] OFF_ID   = 3'd3;
   localparam logic [2:0] OFF_EOI  = 3'd4;
   localparam logic [2:0] OFF_STAT = 3'd5;

   logic [SYNC_STAGES-1:0][N_CHAN-1:0] sync_q;
   logic [N_CHAN-1:0] hist_q;
   logic [N_CHAN-1:0] pending_q, pending_d;
   logic [N_CHAN-1:0] enable_q, enable_d;
   logic [N_CHAN-1:0] edge_q, edge_d;
   logic              in_service_q, in_service_d;
   logic              intrpt_q, intrpt_d;
   logic [ID_W-1:0]   irq_id_q, irq_id_d;
   logic [CNT_W-1:0]  settle_q, settle_d;

   logic              in_win, wr_pend, wr_en, wr_edge, wr_eoi;
   logic              ack_ok, settled;
   logic [2:0]        off;
   logic [N_CHAN-1:0] wdata, sync_lvl, rise, clr, req;
   logic [ID_W-1:0]   winner;
   logic              unused_ok;

   // Bus decode; byte lane bits and write data above N_CHAN are don't-care.
   assign in_win    = iobus_addr[31:5] == BASE_ADDR[31:5];
   assign off       = iobus_addr[4:2];
   assign wr_pend   = iobus_wr & in_win & (off == OFF_PEND);
   assign wr_en     = iobus_wr & in_win & (off == OFF_EN);
   assign wr_edge   = iobus_wr & in_win & (off == OFF_EDGE);
   assign wr_eoi    = iobus_wr & in_win & (off == OFF_EOI);
   assign wdata     = iobus_out[N_CHAN-1:0];
   assign unused_ok = ^{iobus_addr[1:0], iobus_out};

   // Edge history is only trusted once the synchronizers and history have refilled after reset.
   assign settled  = settle_q == CNT_W'(SETTLE);
   assign sync_lvl = sync_q[SYNC_STAGES-1];
   assign rise     = sync_lvl & ~hist_q & {N_CHAN{settled}};
   assign clr      = wr_pend ? wdata : '0;
   assign req      = pending_q & enable_q;
   assign ack_ok   = intrpt_ack & intrpt_q;

   always_comb begin
      winner = '0;
      for (int i = int'(N_CHAN) - 1; i >= 0; i--) begin
         if (req[i]) winner = ID_W'(i);
      end
   end

   always_comb begin
      enable_d     = wr_en ? wdata : enable_q;
      edge_d       = wr_edge ? wdata : edge_q;
      settle_d     = settled ? settle_q : settle_q + CNT_W'(1);
      // Newly edge-mode channels start cleared; a rising edge beats a same-cycle clear.
      pending_d    = (edge_d & edge_q & ((pending_q & ~clr) | rise)) | (~edge_d & sync_lvl);
      in_service_d = in_service_q;
      if (ack_ok) begin
         in_service_d = 1'b1;
      end else if (wr_eoi) begin
         in_service_d = 1'b0;
      end
      intrpt_d     = (|req) & ~in_service_d;
      irq_id_d     = in_service_d ? irq_id_q : winner;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q       <= '0;
         hist_q       <= '0;
         pending_q    <= '0;
         enable_q     <= '0;
         edge_q       <= '0;
         in_service_q <= 1'b0;
         intrpt_q     <= 1'b0;
         irq_id_q     <= '0;
         settle_q     <= '0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], irq_src};
         hist_q       <= sync_lvl;
         pending_q    <= pending_d;
         enable_q     <= enable_d;
         edge_q       <= edge_d;
         in_service_q <= in_service_d;
         intrpt_q     <= intrpt_d;
         irq_id_q     <= irq_id_d;
         settle_q     <= settle_d;
      end
   end

   always_comb begin
      iobus_rd_data = '0;
      if (in_win) begin
         case (off)
            OFF_PEND: iobus_rd_data = 32'(pending_q);
            OFF_EN:   iobus_rd_data = 32'(enable_q);
            OFF_EDGE: iobus_rd_data = 32'(edge_q);
            OFF_ID:   iobus_rd_data = 32'(irq_id_q);
            OFF_STAT: iobus_rd_data = {30'b0, in_service_q, intrpt_q};
            default:  iobus_rd_data = '0;
         endcase
      end
   end

   assign intrpt = intrpt_q;
   assign irq_id = irq_id_q;

endmodule
